// File: rtl/mips_mem_pkg.sv
// Shared definitions for the core data memory: MMIO register offsets,
// STATUS bit layout and the address-region classification.
package mips_mem_pkg;

  // MMIO register byte offsets from mmio_base (low nibble of the offset)
  localparam logic [3:0] MMIO_CONSOLE = 4'h0;
  localparam logic [3:0] MMIO_STATUS  = 4'h4;
  localparam logic [3:0] MMIO_CYCLES  = 4'h8;
  localparam logic [3:0] MMIO_CLEAR   = 4'hC;

  // MMIO window spans four 32-bit registers
  localparam int unsigned MMIO_BYTES = 16;

  // STATUS register layout: {overflow, misalign, 26'b0, count[3:0]}
  localparam int STATUS_OVF_BIT = 31;
  localparam int STATUS_MIS_BIT = 30;
  localparam int STATUS_CNT_W   = 4;

  typedef enum logic [1:0] {
    REGION_RAM,
    REGION_MMIO,
    REGION_NONE
  } region_e;

endpackage

// File: rtl/console_fifo.sv
// Synchronous FIFO feeding the console byte stream.
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   push, push_data - enqueue request and data
//   pop             - dequeue request (ignored when empty)
//   head            - registered head entry
//   count           - current occupancy (0..depth)
//   full, empty     - registered occupancy flags
// A push while full is accepted only if a pop retires an entry in the same
// cycle; otherwise the push is dropped and the caller flags it.
module console_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [width-1:0]       push_data,
  input  logic                   pop,
  output logic [width-1:0]       head,
  output logic [$clog2(depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int CNT_W = $clog2(depth) + 1;

  logic [width-1:0] r_mem [depth];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_full;
  logic             r_empty;
  logic [width-1:0] r_head;

  logic             w_pop;
  logic             w_push;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [CNT_W-1:0] w_count_after_pop;
  logic [CNT_W-1:0] w_count_nxt;
  logic [width-1:0] w_head_nxt;

  assign w_pop             = pop & ~r_empty;
  assign w_push            = push & (~r_full | w_pop);
  assign w_rd_ptr_nxt      = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
  assign w_count_after_pop = r_count - CNT_W'(w_pop);
  assign w_count_nxt       = w_count_after_pop + CNT_W'(w_push);

  // The array write lands on the same edge, so a push into a FIFO that is
  // empty after this cycle's pop must bypass straight into the head register.
  assign w_head_nxt = (w_push && (w_count_after_pop == '0)) ? push_data
                                                            : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_head   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_full   <= (w_count_nxt == CNT_W'(depth));
      r_empty  <= (w_count_nxt == '0);
      r_head   <= w_head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  assign head  = r_head;
  assign count = r_count;
  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/data_mem.sv
// Word-organised data memory with an MMIO window, attached to the core data
// port. Loads have one cycle of registered latency.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   rd_wr      - 1 = load, 0 = store (every cycle is an access)
//   addr       - byte address
//   wr_data    - store data
//   rd_data    - registered load data, held across store cycles
//   tx_data    - console byte at FIFO head
//   tx_valid   - console FIFO non-empty
//   tx_ready   - consumer takes the head when tx_valid & tx_ready
// MMIO: CONSOLE (push byte), STATUS (flags + FIFO count), CYCLES (free-running
// counter), CLEAR (wr_data[0] clears sticky flags).
module data_mem
  import mips_mem_pkg::*;
#(
  parameter logic [31:0] base_addr   = 32'h0000_0000,
  parameter int          depth_words = 16384,
  parameter logic [31:0] mmio_base   = 32'hFFFF_0000,
  parameter int          fifo_depth  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          IDX_W     = $clog2(depth_words);
  localparam int          CNT_W     = $clog2(fifo_depth) + 1;
  localparam logic [32:0] RAM_BYTES = 33'(depth_words) * 33'd4;

  logic [31:0]      r_ram [depth_words];
  logic [31:0]      r_rd_data;
  logic [31:0]      r_cycles;
  logic             r_ovf;
  logic             r_mis;

  logic [31:0]      w_ram_off;
  logic [31:0]      w_mmio_off;
  logic [IDX_W-1:0] w_idx;
  logic [3:0]       w_reg;
  region_e          w_region;
  logic             w_misalign;
  logic             w_wr_ok;
  logic             w_ram_we;
  logic             w_push;
  logic             w_pop;
  logic             w_clear;
  logic             w_ovf_set;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  logic [7:0]       w_head;
  logic [31:0]      w_status;
  logic [31:0]      w_rd_val;

  // Offsets wrap for addresses below a base; the 33-bit compare keeps those out.
  assign w_ram_off  = addr - base_addr;
  assign w_mmio_off = addr - mmio_base;
  assign w_idx      = w_ram_off[IDX_W+1:2];
  assign w_reg      = w_mmio_off[3:0];
  assign w_misalign = (addr[1:0] != 2'b00);

  always_comb begin
    w_region = REGION_NONE;
    if ({1'b0, w_ram_off} < RAM_BYTES) begin
      w_region = REGION_RAM;
    end else if (w_mmio_off < MMIO_BYTES) begin
      w_region = REGION_MMIO;
    end
  end

  // A store sampled together with reset is discarded everywhere, RAM included.
  assign w_wr_ok   = !reset && !rd_wr && !w_misalign;
  assign w_ram_we  = w_wr_ok && (w_region == REGION_RAM);
  assign w_push    = w_wr_ok && (w_region == REGION_MMIO) && (w_reg == MMIO_CONSOLE);
  assign w_clear   = w_wr_ok && (w_region == REGION_MMIO) && (w_reg == MMIO_CLEAR)
                     && wr_data[0];
  assign w_pop     = tx_valid & tx_ready;
  assign w_ovf_set = w_push && w_full && !w_pop;

  console_fifo #(
    .width (8),
    .depth (fifo_depth)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (wr_data[7:0]),
    .pop       (w_pop),
    .head      (w_head),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_comb begin
    w_status                 = '0;
    w_status[STATUS_OVF_BIT] = r_ovf;
    w_status[STATUS_MIS_BIT] = r_mis;
    w_status[STATUS_CNT_W-1:0] = STATUS_CNT_W'(w_count);
  end

  always_comb begin
    w_rd_val = '0;
    if (!w_misalign) begin
      case (w_region)
        REGION_RAM:  w_rd_val = r_ram[w_idx];
        REGION_MMIO: begin
          case (w_reg)
            MMIO_STATUS: w_rd_val = w_status;
            MMIO_CYCLES: w_rd_val = r_cycles;
            default:     w_rd_val = '0;
          endcase
        end
        default:     w_rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_ram[w_idx] <= wr_data;
    end
  end

  // Flag set has priority over a CLEAR landing on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
      r_cycles  <= '0;
      r_ovf     <= 1'b0;
      r_mis     <= 1'b0;
    end else begin
      if (rd_wr) begin
        r_rd_data <= w_rd_val;
      end
      r_cycles <= r_cycles + 32'd1;
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (w_clear) begin
        r_ovf <= 1'b0;
      end
      if (w_misalign) begin
        r_mis <= 1'b1;
      end else if (w_clear) begin
        r_mis <= 1'b0;
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign tx_data  = w_head;
  assign tx_valid = ~w_empty;

endmodule

// File: tb/tb_data_mem.sv
module tb_data_mem;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 16384;
  localparam logic [31:0] MMIO  = 32'hFFFF_0000;
  localparam int          FD    = 4;
  localparam logic [31:0] IDLE  = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_wr;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  data_mem #(
    .base_addr   (BASE),
    .depth_words (DEPTH),
    .mmio_base   (MMIO),
    .fifo_depth  (FD)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_wr    (rd_wr),
    .addr     (addr),
    .wr_data  (wr_data),
    .rd_data  (rd_data),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state
  logic [31:0] ram_m [bit [31:0]];
  logic [7:0]  mfifo [$];
  logic        m_ovf = 1'b0;
  logic        m_mis = 1'b0;
  logic [31:0] m_cyc = '0;

  // Scoreboards
  logic [31:0] rdq [$];
  logic [7:0]  txq [$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void model(bit rst, bit rw, logic [31:0] a, logic [31:0] d, bit rdy);
    logic [31:0] exp;
    longint      la;
    bit          mis, in_ram, pop, new_ovf, clr;
    la     = a;
    mis    = (a[1:0] != 2'b00);
    in_ram = (la >= longint'(BASE)) && (la < longint'(BASE) + 4 * DEPTH);
    if (rst) begin
      rdq.push_back(32'h0);
      mfifo.delete();
      txq.delete();
      m_ovf = 1'b0;
      m_mis = 1'b0;
      m_cyc = '0;
      return;
    end
    if (rw) begin
      exp = '0;
      if (!mis) begin
        if (in_ram) exp = ram_m[(a - BASE) >> 2];
        else if (a == MMIO + 32'h4) exp = {m_ovf, m_mis, 26'b0, 4'(mfifo.size())};
        else if (a == MMIO + 32'h8) exp = m_cyc;
      end
      rdq.push_back(exp);
    end
    pop     = (mfifo.size() > 0) && rdy;
    new_ovf = 1'b0;
    clr     = 1'b0;
    if (pop) void'(mfifo.pop_front());
    if (!rw && !mis) begin
      if (in_ram) ram_m[(a - BASE) >> 2] = d;
      else if (a == MMIO) begin
        if (mfifo.size() < FD) begin
          mfifo.push_back(d[7:0]);
          txq.push_back(d[7:0]);
        end else begin
          new_ovf = 1'b1;
        end
      end else if (a == MMIO + 32'hC && d[0]) clr = 1'b1;
    end
    if (clr) begin
      m_ovf = 1'b0;
      m_mis = 1'b0;
    end
    if (new_ovf) m_ovf = 1'b1;
    if (mis) m_mis = 1'b1;
    m_cyc = m_cyc + 32'd1;
  endfunction

  task automatic step(input bit rst, input bit rw, input logic [31:0] a,
                      input logic [31:0] d, input bit rdy);
    reset    = rst;
    rd_wr    = rw;
    addr     = a;
    wr_data  = d;
    tx_ready = rdy;
    model(rst, rw, a, d, rdy);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b1, IDLE, 32'h0, rdy);
  endtask

  // Monitor: inputs change 2 time units after the edge, so at +1 they still
  // hold the values that were sampled on this edge.
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = '0;

  always @(posedge clk) begin
    #1;
    if (reset || rd_wr) begin
      if (rdq.size() == 0) chk("rdq_underflow", 32'd0, 32'd1);
      else chk("rd_data", rd_data, rdq.pop_front());
    end
    if (!reset && prev_valid && tx_ready) begin
      if (txq.size() == 0) chk("txq_underflow", {24'd0, prev_data}, 32'hFFFF_FFFF);
      else chk("tx_data", {24'd0, prev_data}, {24'd0, txq.pop_front()});
    end
    chk("tx_valid", {31'd0, tx_valid}, {31'd0, (txq.size() != 0)});
    prev_valid = tx_valid;
    prev_data  = tx_data;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          r;
    // Reset, with a load pending so rd_data must stay 0
    step(1'b1, 1'b1, BASE + 32'h10, 32'h0, 1'b0);
    step(1'b1, 1'b0, BASE + 32'h10, 32'h0, 1'b0);

    // Initialise the RAM words used later, plus the last word
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, BASE + 32'(i * 4), 32'h0, 1'b0);
    step(1'b0, 1'b0, BASE + 32'(4 * DEPTH - 4), 32'hCAFE_F00D, 1'b0);
    // One past the top of RAM is unmapped: must not alias word 0
    step(1'b0, 1'b0, BASE + 32'(4 * DEPTH), 32'h5555_5555, 1'b0);
    step(1'b0, 1'b1, BASE, 32'h0, 1'b0);
    step(1'b0, 1'b1, BASE + 32'(4 * DEPTH - 4), 32'h0, 1'b0);
    step(1'b0, 1'b1, BASE + 32'(4 * DEPTH), 32'h0, 1'b0);

    // Store then immediate load of the same word
    step(1'b0, 1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 1'b0);
    step(1'b0, 1'b1, BASE + 32'h10, 32'h0, 1'b0);
    step(1'b0, 1'b0, BASE + 32'h14, 32'h1111_2222, 1'b0);
    idle(1'b0);

    // Overfill the console FIFO, read STATUS, then drain
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, MMIO, 32'h41 + 32'(i), 1'b0);
    step(1'b0, 1'b1, MMIO + 32'h4, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);
    step(1'b0, 1'b1, MMIO + 32'h4, 32'h0, 1'b0);

    // Full FIFO with a pop and push on the same edge: no overflow
    step(1'b0, 1'b0, MMIO + 32'hC, 32'h1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, MMIO, 32'h30 + 32'(i), 1'b0);
    step(1'b0, 1'b0, MMIO, 32'h5A, 1'b1);
    step(1'b0, 1'b1, MMIO + 32'h4, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Misaligned load, then clear the sticky flags
    step(1'b0, 1'b1, BASE + 32'h2, 32'h0, 1'b0);
    step(1'b0, 1'b1, MMIO + 32'h4, 32'h0, 1'b0);
    step(1'b0, 1'b0, MMIO + 32'hC, 32'h1, 1'b0);
    step(1'b0, 1'b1, MMIO + 32'h4, 32'h0, 1'b0);
    // Misaligned store and CLEAR on the same... separate edges; set then clear race
    step(1'b0, 1'b0, BASE + 32'h13, 32'h7777_7777, 1'b0);
    step(1'b0, 1'b1, BASE + 32'h10, 32'h0, 1'b0);
    step(1'b0, 1'b1, MMIO + 32'h4, 32'h0, 1'b0);
    step(1'b0, 1'b0, MMIO + 32'hC, 32'h1, 1'b0);

    // CYCLES at edges k and k+10
    step(1'b0, 1'b1, MMIO + 32'h8, 32'h0, 1'b0);
    for (int i = 0; i < 9; i++) idle(1'b0);
    step(1'b0, 1'b1, MMIO + 32'h8, 32'h0, 1'b0);

    // Counter wrap: preload 0xFFFF_FFFE so it reads 0xFFFF_FFFF then 0
    reset = 1'b0; rd_wr = 1'b1; addr = IDLE; wr_data = '0; tx_ready = 1'b0;
    model(1'b0, 1'b1, IDLE, 32'h0, 1'b0);
    m_cyc = 32'hFFFF_FFFF;
    force dut.r_cycles = 32'hFFFF_FFFE;
    #5;
    release dut.r_cycles;
    @(posedge clk);
    #2;
    step(1'b0, 1'b1, MMIO + 32'h8, 32'h0, 1'b0);
    step(1'b0, 1'b1, MMIO + 32'h8, 32'h0, 1'b0);

    // Randomised mix of accesses
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 10);
      case (r)
        0, 1, 2: a = BASE + (32'($urandom_range(0, 7)) << 2);
        3:       a = BASE + 32'(4 * DEPTH - 4);
        4:       a = MMIO;
        5:       a = MMIO + 32'h4;
        6:       a = MMIO + 32'h8;
        7:       a = MMIO + 32'hC;
        8:       a = ($urandom_range(0, 1) != 0) ? IDLE : BASE + 32'(4 * DEPTH);
        9:       a = MMIO + 32'($urandom_range(1, 3));
        default: a = BASE + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(1, 3));
      endcase
      step(1'b0, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset on the same edge as a store: the store is discarded
    step(1'b0, 1'b0, BASE, 32'h0, 1'b0);
    step(1'b0, 1'b0, MMIO, 32'h99, 1'b0);
    step(1'b0, 1'b1, BASE + 32'h1, 32'h0, 1'b0);
    step(1'b1, 1'b0, BASE, 32'h1234, 1'b0);
    step(1'b0, 1'b1, BASE, 32'h0, 1'b0);
    step(1'b0, 1'b1, MMIO + 32'h4, 32'h0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    chk("rdq_left", 32'(rdq.size()), 32'd0);
    chk("txq_left", 32'(txq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
